display_decoder: RTL and testbench
==================================

DISPLAY_DECODER -- requirements
Module: display_decoder

Parameters
REQ-001 STABLE_CYCLES, 4, consecutive synchronized cycles a digit/segment pattern must hold before capture (range 2..15).
REQ-002 TIMEOUT_CYCLES, 65535, cycles without a capture before the frame is abandoned and display_off asserts.

Interface
REQ-003 Clock  input  1  sole clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 nDigit  input  4  multiplexed digit strobes, active-low, bit i = digit i.
REQ-006 SegA..SegG  input  1 each  segment drives, active-high.
REQ-007 DP  input  1  decimal point of the strobed digit, active-high.
REQ-008 digit_code  output  16  four 4-bit codes, [4i+3:4i] = digit i, updated only at frame publish.
REQ-009 dp_out  output  4  captured DP per digit, updated with digit_code.
REQ-010 frame_valid  output  1  one-cycle pulse when digit_code/dp_out/frame_err are refreshed.
REQ-011 frame_err  output  1  high if any digit of the published frame had an invalid pattern; valid with frame_valid and held.
REQ-012 display_off  output  1  level; high after timeout, low at next capture.

Function
REQ-013 All 12 inputs SHALL pass through a 2-flop synchronizer; decoder logic uses synchronized values only.
REQ-014 Digit selection valid only when exactly one nDigit bit is low; zero or multiple low = no digit, stability counter cleared.
REQ-015 Stability counter increments while selected digit index and {SegA..SegG,DP} are unchanged versus the previous cycle; any change reloads it to 1.
REQ-016 Capture occurs on the cycle the counter reaches STABLE_CYCLES; exactly one capture per strobe activation until index or pattern changes.
REQ-017 Decode: standard 7-segment 0-9 -> 4'h0-4'h9; all segments off -> 4'hA (blank); SegG only -> 4'hB (minus); anything else -> 4'hF and sets the shadow error bit.
REQ-018 Capture writes code and DP into shadow register i and sets seen-mask bit i; re-capture of a digit already seen overwrites its shadow entry.
REQ-019 FSM states: IDLE (mask empty), COLLECT (mask partial), PUBLISH (one cycle).
REQ-020 IDLE -> COLLECT on first capture; COLLECT -> PUBLISH on the capture completing mask 4'b1111; PUBLISH -> IDLE unconditionally.
REQ-021 In PUBLISH: shadow copied to digit_code/dp_out atomically, frame_err = shadow error, frame_valid = 1, mask and shadow error cleared.
REQ-022 Frame latency: frame_valid asserts exactly 1 cycle after the completing capture.
REQ-023 A capture coinciding with PUBLISH SHALL be applied to the new (cleared) mask, not lost.
REQ-024 Idle counter counts cycles since last capture, saturating; at TIMEOUT_CYCLES: mask cleared, FSM -> IDLE, display_off = 1; published outputs retained.
REQ-025 Capture resets the idle counter and clears display_off in the same cycle.

Reset
REQ-026 Reset SHALL asynchronously clear: synchronizers to inactive (nDigit 4'hF, segments 0), counters 0, mask 0, FSM IDLE, digit_code 16'hAAAA, dp_out 0, frame_valid 0, frame_err 0, display_off 0.
REQ-027 Reset mid-frame SHALL discard partial shadow content; no frame_valid until four fresh captures after release.

Structure
REQ-028 Package display_pkg SHALL hold the segment-pattern constants, the 4-bit code constants (blank, minus, invalid), and the FSM state typedef.
REQ-029 Pattern-to-code translation SHALL be a combinational sub-module seg7_decode (7-bit in, 4-bit code + invalid flag out).

Verification
REQ-030 Strobe digits 0..3 with patterns for 1,2,3,4, each held 8 cycles -> one frame_valid, digit_code 16'h4321, frame_err 0.
REQ-031 Digit 2 pattern held only STABLE_CYCLES-1 cycles, then digits 0,1,3 -> no frame_valid until a digit-2 hold of >= STABLE_CYCLES.
REQ-032 Digit 1 = SegA+SegB only, others valid -> frame_valid with digit 1 code 4'hF and frame_err 1; next clean frame -> frame_err 0.
REQ-033 nDigit = 4'b1100 for 20 cycles -> no capture, counter held at 0.
REQ-034 Three digits captured, then no strobes for TIMEOUT_CYCLES -> display_off 1, previous digit_code unchanged; next capture -> display_off 0.
REQ-035 Reset asserted after two captures, released, then full frame -> frame_valid only after four post-reset captures, digit_code 16'hAAAA until then.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment display decoder.
// Segment patterns are 7-bit vectors ordered {G,F,E,D,C,B,A} (SegA in bit 0).
package display_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [3:0] CODE_BLANK   = 4'hA;
  localparam logic [3:0] CODE_MINUS   = 4'hB;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to 4-bit code translation.
// Ports:
//   seg_i     - segment pattern {G,F,E,D,C,B,A}
//   code_o    - 0..9, CODE_BLANK, CODE_MINUS or CODE_INVALID
//   invalid_o - high when the pattern is not a recognised glyph
module seg7_decode
  import display_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] code_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = CODE_INVALID;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     code_o = 4'h0;
      SEG_1:     code_o = 4'h1;
      SEG_2:     code_o = 4'h2;
      SEG_3:     code_o = 4'h3;
      SEG_4:     code_o = 4'h4;
      SEG_5:     code_o = 4'h5;
      SEG_6:     code_o = 4'h6;
      SEG_7:     code_o = 4'h7;
      SEG_8:     code_o = 4'h8;
      SEG_9:     code_o = 4'h9;
      SEG_BLANK: code_o = CODE_BLANK;
      SEG_MINUS: code_o = CODE_MINUS;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_decoder.sv
// Recovers the four digits shown on a multiplexed 7-segment display by
// watching its strobe and segment lines, and publishes them as a frame.
// Ports:
//   Clock, Reset      - clock and asynchronous active-high reset
//   nDigit            - active-low digit strobes (bit i = digit i)
//   SegA..SegG, DP    - active-high segment and decimal-point drives
//   digit_code        - published codes, [4i+3:4i] = digit i
//   dp_out            - published decimal points
//   frame_valid       - one-cycle pulse when the published outputs refresh
//   frame_err         - published frame contained an unrecognised pattern
//   display_off       - no capture seen for TIMEOUT_CYCLES cycles
module display_decoder
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  nDigit,
  input  logic        SegA,
  input  logic        SegB,
  input  logic        SegC,
  input  logic        SegD,
  input  logic        SegE,
  input  logic        SegF,
  input  logic        SegG,
  input  logic        DP,
  output logic [15:0] digit_code,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        display_off
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0]        STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);
  // {nDigit, G..A, DP} with strobes inactive and segments dark
  localparam logic [11:0]       SYNC_IDLE  = 12'hF00;

  logic [11:0]       sync_raw, sync_p0_q, sync_p1_q;
  logic [3:0]        nd_s;
  logic [7:0]        pat_s;
  logic              sel_vld;
  logic [1:0]        sel_idx;
  logic [3:0]        stab_q, stab_d;
  logic [1:0]        prev_idx_q;
  logic [7:0]        prev_pat_q;
  logic              capture;
  logic [3:0]        dec_code;
  logic              dec_inv;
  logic [3:0][3:0]   shad_code_q, shad_code_d;
  logic [3:0]        shad_dp_q, shad_dp_d;
  logic [3:0]        mask_q, mask_d;
  logic              err_q, err_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout;
  state_e            state_q;
  logic [15:0]       digit_code_q;
  logic [3:0]        dp_out_q;
  logic              frame_valid_q, frame_err_q, display_off_q;

  // Stage p0/p1: two-flop synchronizer on every input line
  assign sync_raw = {nDigit, SegG, SegF, SegE, SegD, SegC, SegB, SegA, DP};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_p0_q <= SYNC_IDLE;
      sync_p1_q <= SYNC_IDLE;
    end else begin
      sync_p0_q <= sync_raw;
      sync_p1_q <= sync_p0_q;
    end
  end

  assign nd_s  = sync_p1_q[11:8];
  assign pat_s = sync_p1_q[7:0];

  always_comb begin
    sel_vld = 1'b1;
    sel_idx = 2'd0;
    case (nd_s)
      4'b1110: sel_idx = 2'd0;
      4'b1101: sel_idx = 2'd1;
      4'b1011: sel_idx = 2'd2;
      4'b0111: sel_idx = 2'd3;
      default: sel_vld = 1'b0;
    endcase
  end

  // A zero count means the previous cycle had no valid strobe, so the
  // stored index/pattern are meaningless and the run restarts at 1.
  always_comb begin
    stab_d = 4'd0;
    if (sel_vld) begin
      if (stab_q != 4'd0 && sel_idx == prev_idx_q && pat_s == prev_pat_q)
        stab_d = (stab_q == STABLE_MAX) ? stab_q : stab_q + 4'd1;
      else
        stab_d = 4'd1;
    end
  end

  // Saturating at STABLE_MAX yields exactly one capture per steady strobe.
  assign capture = sel_vld && (stab_d == STABLE_MAX) && (stab_q != STABLE_MAX);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stab_q     <= 4'd0;
      prev_idx_q <= 2'd0;
      prev_pat_q <= 8'd0;
    end else begin
      stab_q     <= stab_d;
      prev_idx_q <= sel_idx;
      prev_pat_q <= pat_s;
    end
  end

  seg7_decode u_dec (
    .seg_i     (pat_s[7:1]),
    .code_o    (dec_code),
    .invalid_o (dec_inv)
  );

  always_comb begin
    shad_code_d = shad_code_q;
    shad_dp_d   = shad_dp_q;
    mask_d      = mask_q;
    err_d       = err_q;
    if (capture) begin
      shad_code_d[sel_idx] = dec_code;
      shad_dp_d[sel_idx]   = pat_s[0];
      mask_d[sel_idx]      = 1'b1;
      err_d                = err_q | dec_inv;
    end
    idle_d  = capture ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + 1'b1);
    timeout = !capture && (idle_q == IDLE_MAX - 1'b1);
  end

  // Shadow entries are only meaningful under their mask bit, so they need no reset.
  always_ff @(posedge Clock) begin
    shad_code_q <= shad_code_d;
    shad_dp_q   <= shad_dp_d;
  end

  // Stage p2: frame assembly FSM. Published outputs load on the edge that
  // enters PUBLISH (from the shadow including the completing capture), so
  // frame_valid is high during PUBLISH and the mask is already empty there,
  // letting a capture in that cycle start the next frame.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      mask_q        <= 4'd0;
      err_q         <= 1'b0;
      idle_q        <= '0;
      digit_code_q  <= 16'hAAAA;
      dp_out_q      <= 4'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      display_off_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      idle_q        <= idle_d;
      if (capture)      display_off_q <= 1'b0;
      else if (timeout) display_off_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_PUBLISH: begin
          if (capture) begin
            mask_q  <= mask_d;
            err_q   <= err_d;
            state_q <= ST_COLLECT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (capture && mask_d == 4'hF) begin
            digit_code_q  <= shad_code_d;
            dp_out_q      <= shad_dp_d;
            frame_err_q   <= err_d;
            frame_valid_q <= 1'b1;
            mask_q        <= 4'd0;
            err_q         <= 1'b0;
            state_q       <= ST_PUBLISH;
          end else if (capture) begin
            mask_q <= mask_d;
            err_q  <= err_d;
          end else if (timeout) begin
            mask_q  <= 4'd0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign digit_code  = digit_code_q;
  assign dp_out      = dp_out_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign display_off = display_off_q;

endmodule

// File: tb/tb_display_decoder.sv
// Bench for display_decoder: directed scenarios plus random strobing,
// compared each cycle against a run-length reference model.
module tb_display_decoder;

  localparam int STABLE = 4;
  localparam int TMO    = 300;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  nDigit = 4'hF;
  logic        SegA = 0, SegB = 0, SegC = 0, SegD = 0, SegE = 0, SegF = 0, SegG = 0, DP = 0;
  logic [15:0] digit_code;
  logic [3:0]  dp_out;
  logic        frame_valid, frame_err, display_off;

  display_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .nDigit(nDigit),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE), .SegF(SegF), .SegG(SegG),
    .DP(DP), .digit_code(digit_code), .dp_out(dp_out), .frame_valid(frame_valid),
    .frame_err(frame_err), .display_off(display_off)
  );

  always #5 Clock = ~Clock;

  logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int    checks = 0;
  int    errors = 0;
  int    dut_fv = 0;
  int    fv0;
  string cur_tag = "reset";

  // Reference model: inputs delayed two cycles, then steady-run counting
  logic [3:0]  m_d1_nd, m_d2_nd;
  logic [7:0]  m_d1_pat, m_d2_pat;
  logic        m_prev_vld;
  int          m_prev_idx;
  logic [7:0]  m_prev_pat;
  int          m_run, m_idle;
  logic [3:0]  m_seen;
  logic        m_err;
  logic [3:0]  m_shcode [4];
  logic        m_shdp [4];
  logic [15:0] m_code;
  logic [3:0]  m_dpo;
  logic        m_fv, m_ferr, m_off;

  task automatic decode(input logic [6:0] s, output logic [3:0] c, output logic inv);
    c = 4'hF; inv = 1'b1;
    for (int i = 0; i < 10; i++) if (s == SEGTAB[i]) begin c = 4'(i); inv = 1'b0; end
    if (s == 7'h00) begin c = 4'hA; inv = 1'b0; end
    if (s == 7'h40) begin c = 4'hB; inv = 1'b0; end
  endtask

  task automatic model_reset();
    m_d1_nd = 4'hF; m_d2_nd = 4'hF; m_d1_pat = 8'h00; m_d2_pat = 8'h00;
    m_prev_vld = 1'b0; m_prev_idx = 0; m_prev_pat = 8'h00;
    m_run = 0; m_idle = 0; m_seen = 4'h0; m_err = 1'b0;
    m_code = 16'hAAAA; m_dpo = 4'h0; m_fv = 1'b0; m_ferr = 1'b0; m_off = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] nd, input logic [7:0] pat);
    logic       vld, cap, inv;
    int         idx;
    logic [3:0] c;
    if (Reset) begin
      model_reset();
      return;
    end
    vld = ($countones(~m_d2_nd) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (!m_d2_nd[i]) idx = i;
    if (!vld) m_run = 0;
    else if (m_prev_vld && idx == m_prev_idx && m_d2_pat == m_prev_pat) m_run++;
    else m_run = 1;
    cap = vld && (m_run == STABLE);
    m_prev_vld = vld; m_prev_idx = idx; m_prev_pat = m_d2_pat;
    m_fv = 1'b0;
    if (cap) begin
      decode(m_d2_pat[7:1], c, inv);
      m_shcode[idx] = c; m_shdp[idx] = m_d2_pat[0];
      m_seen[idx] = 1'b1; m_err = m_err | inv;
      m_idle = 0; m_off = 1'b0;
      if (m_seen == 4'hF) begin
        m_code = {m_shcode[3], m_shcode[2], m_shcode[1], m_shcode[0]};
        m_dpo  = {m_shdp[3], m_shdp[2], m_shdp[1], m_shdp[0]};
        m_ferr = m_err; m_fv = 1'b1; m_seen = 4'h0; m_err = 1'b0;
      end
    end else if (m_idle < TMO) begin
      m_idle++;
      if (m_idle == TMO) begin m_seen = 4'h0; m_err = 1'b0; m_off = 1'b1; end
    end
    m_d2_nd = m_d1_nd; m_d2_pat = m_d1_pat;
    m_d1_nd = nd;      m_d1_pat = pat;
  endtask

  task automatic check_all();
    checks++;
    assert (digit_code === m_code) else begin
      errors++; $error("FAIL %s digit_code observed=%h expected=%h", cur_tag, digit_code, m_code); end
    checks++;
    assert (dp_out === m_dpo) else begin
      errors++; $error("FAIL %s dp_out observed=%b expected=%b", cur_tag, dp_out, m_dpo); end
    checks++;
    assert (frame_valid === m_fv) else begin
      errors++; $error("FAIL %s frame_valid observed=%b expected=%b", cur_tag, frame_valid, m_fv); end
    checks++;
    assert (frame_err === m_ferr) else begin
      errors++; $error("FAIL %s frame_err observed=%b expected=%b", cur_tag, frame_err, m_ferr); end
    checks++;
    assert (display_off === m_off) else begin
      errors++; $error("FAIL %s display_off observed=%b expected=%b", cur_tag, display_off, m_off); end
    if (frame_valid === 1'b1) dut_fv++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end
  endtask

  task automatic tick(input logic [3:0] nd, input logic [6:0] seg, input logic dp);
    nDigit = nd;
    {SegG, SegF, SegE, SegD, SegC, SegB, SegA} = seg;
    DP = dp;
    @(posedge Clock);
    model_edge(nd, {seg, dp});
    @(negedge Clock);
    check_all();
  endtask

  task automatic strobe(input int idx, input logic [6:0] seg, input logic dp, input int n);
    logic [3:0] nd;
    nd = 4'b0001 << idx;
    nd = ~nd;
    repeat (n) tick(nd, seg, dp);
  endtask

  task automatic gap(input int n);
    repeat (n) tick(4'hF, 7'h00, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    gap(2);
    Reset = 1'b0;
  endtask

  initial begin
    logic [3:0] nd;
    logic [6:0] seg;
    int         k;
    model_reset();
    for (int i = 0; i < 4; i++) begin m_shcode[i] = 4'h0; m_shdp[i] = 1'b0; end
    @(negedge Clock);
    check_all();
    chk("reset_code", 32'(digit_code), 32'h0000AAAA);
    chk("reset_flags", 32'({dp_out, frame_valid, frame_err, display_off}), 32'h0);
    gap(2);
    Reset = 1'b0;
    gap(3);

    cur_tag = "basic_frame";
    fv0 = dut_fv;
    strobe(0, SEGTAB[1], 1'b0, 8); strobe(1, SEGTAB[2], 1'b0, 8);
    strobe(2, SEGTAB[3], 1'b0, 8); strobe(3, SEGTAB[4], 1'b0, 8);
    gap(4);
    chk("basic_frames", 32'(dut_fv - fv0), 32'd1);
    chk("basic_code", 32'(digit_code), 32'h00004321);
    chk("basic_err", 32'(frame_err), 32'd0);

    cur_tag = "short_hold";
    fv0 = dut_fv;
    strobe(2, SEGTAB[7], 1'b0, STABLE - 1);
    strobe(0, SEGTAB[5], 1'b0, 8); strobe(1, SEGTAB[6], 1'b0, 8); strobe(3, SEGTAB[8], 1'b0, 8);
    gap(4);
    chk("short_no_frame", 32'(dut_fv - fv0), 32'd0);
    strobe(2, SEGTAB[7], 1'b0, 8);
    gap(4);
    chk("short_frames", 32'(dut_fv - fv0), 32'd1);
    chk("short_code", 32'(digit_code), 32'h00008765);

    cur_tag = "bad_digit";
    strobe(0, SEGTAB[9], 1'b0, 8); strobe(1, 7'h03, 1'b0, 8);
    strobe(2, 7'h40, 1'b0, 8);     strobe(3, 7'h00, 1'b0, 8);
    gap(4);
    chk("bad_code", 32'(digit_code), 32'h0000ABF9);
    chk("bad_err", 32'(frame_err), 32'd1);
    strobe(0, SEGTAB[1], 1'b0, 8); strobe(1, SEGTAB[2], 1'b0, 8);
    strobe(2, SEGTAB[3], 1'b1, 8); strobe(3, SEGTAB[4], 1'b0, 8);
    gap(4);
    chk("clean_err", 32'(frame_err), 32'd0);
    chk("clean_dp", 32'(dp_out), 32'h4);

    cur_tag = "multi_strobe";
    fv0 = dut_fv;
    repeat (20) tick(4'b1100, SEGTAB[8], 1'b0);
    chk("multi_counter", 32'(dut.stab_q), 32'd0);
    chk("multi_no_frame", 32'(dut_fv - fv0), 32'd0);

    cur_tag = "timeout";
    strobe(0, SEGTAB[1], 1'b0, 8); strobe(1, SEGTAB[2], 1'b0, 8); strobe(2, SEGTAB[3], 1'b0, 8);
    gap(TMO + 5);
    chk("timeout_off", 32'(display_off), 32'd1);
    chk("timeout_code", 32'(digit_code), 32'h00004321);
    fv0 = dut_fv;
    strobe(3, SEGTAB[4], 1'b0, 8);
    chk("timeout_clear", 32'(display_off), 32'd0);
    chk("timeout_mask_cleared", 32'(dut_fv - fv0), 32'd0);
    strobe(0, SEGTAB[1], 1'b0, 8); strobe(1, SEGTAB[2], 1'b0, 8); strobe(2, SEGTAB[3], 1'b0, 8);
    gap(4);
    chk("timeout_refill", 32'(dut_fv - fv0), 32'd1);

    cur_tag = "mid_reset";
    strobe(0, SEGTAB[9], 1'b0, 8); strobe(1, SEGTAB[8], 1'b0, 8);
    do_reset();
    fv0 = dut_fv;
    strobe(2, SEGTAB[7], 1'b0, 8); strobe(3, SEGTAB[6], 1'b0, 8); strobe(0, SEGTAB[5], 1'b0, 8);
    gap(4);
    chk("reset_partial_frames", 32'(dut_fv - fv0), 32'd0);
    chk("reset_partial_code", 32'(digit_code), 32'h0000AAAA);
    strobe(1, SEGTAB[4], 1'b0, 8);
    gap(4);
    chk("reset_full_frames", 32'(dut_fv - fv0), 32'd1);
    chk("reset_full_code", 32'(digit_code), 32'h00006745);

    cur_tag = "random";
    for (int b = 0; b < 120; b++) begin
      k = int'($urandom_range(0, 5));
      if (k < 4) begin nd = 4'b0001 << k; nd = ~nd; end
      else if (k == 4) nd = 4'b1100;
      else nd = 4'hF;
      k = int'($urandom_range(0, 12));
      if (k < 10) seg = SEGTAB[k];
      else if (k == 10) seg = 7'h00;
      else if (k == 11) seg = 7'h40;
      else seg = 7'($urandom);
      repeat (int'($urandom_range(1, 8))) tick(nd, seg, 1'($urandom));
    end
    gap(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
